// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin arbiter plus one-entry output register for the common
//            data bus. Picks one result per cycle from the functional units,
//            holds it under consumer back-pressure and drops it on a flush.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_UNITS  = 3,
  parameter int RSV_ID_W = 4,
  parameter int DATA_W   = 32,
  parameter int CDB_W    = RSV_ID_W + DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [N_UNITS-1:0]          i_valid,
  input  logic [N_UNITS*CDB_W-1:0]    i_cdb,
  output logic [N_UNITS-1:0]          i_ready,
  output logic [CDB_W-1:0]            cdb,
  output logic                        cdb_valid,
  input  logic                        cdb_ready,
  output logic [$clog2(N_UNITS)-1:0]  last_grant
);

  localparam int IDX_W = $clog2(N_UNITS);
  // One extra bit so last_grant + offset (offset <= N_UNITS) never overflows
  // before the wrap-around subtraction.
  localparam int SUM_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_UNITS - 1);

  logic [CDB_W-1:0] cdb_q, cdb_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  logic             slot_free;
  logic             grant_found;
  logic             grant_en;
  logic [IDX_W-1:0] grant_idx;
  logic [SUM_W-1:0] cand;
  logic [CDB_W-1:0] unit_cdb [N_UNITS];

  // Split the flat result bus into one word per unit.
  for (genvar k = 0; k < N_UNITS; k++) begin : g_unpack
    assign unit_cdb[k] = i_cdb[k*CDB_W +: CDB_W];
  end

  // The register can take a new word when empty or when its word is consumed
  // this same cycle, which gives back-to-back transfers without a bubble.
  assign slot_free = ~cdb_valid_q | cdb_ready;

  // Round-robin scan starting just after the last granted unit, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int i = 1; i <= N_UNITS; i++) begin
      cand = {1'b0, last_grant_q} + SUM_W'(i);
      if (cand >= SUM_W'(N_UNITS)) begin
        cand = cand - SUM_W'(N_UNITS);
      end
      if (!grant_found && i_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grants are suppressed while resetting or flushing so no result is
  // accepted that would then be discarded.
  assign grant_en = grant_found & slot_free & ~flush & ~rst;

  // One-hot (or zero) grant back to the requesting units.
  for (genvar k = 0; k < N_UNITS; k++) begin : g_ready
    assign i_ready[k] = grant_en && (grant_idx == IDX_W'(k));
  end

  // Next-state for the output register: flush wins, then a new grant, then drain.
  always_comb begin
    cdb_d        = cdb_q;
    cdb_valid_d  = cdb_valid_q;
    last_grant_d = last_grant_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (grant_en) begin
      cdb_d        = unit_cdb[grant_idx];
      cdb_valid_d  = 1'b1;
      last_grant_d = grant_idx;
    end else if (cdb_ready) begin
      cdb_valid_d = 1'b0;
    end
  end

  // Output register; reset leaves unit 0 at top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_q        <= '0;
      cdb_valid_q  <= 1'b0;
      last_grant_q <= LAST_RST;
    end else begin
      cdb_q        <= cdb_d;
      cdb_valid_q  <= cdb_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign cdb        = cdb_q;
  assign cdb_valid  = cdb_valid_q;
  assign last_grant = last_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter (3-unit instance
//            plus a 5-unit instance for the wrap-around case).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int CW  = 36;   // 4-bit tag + 32-bit data
  localparam int CWB = 12;   // 4-bit tag + 8-bit data for the 5-unit instance

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [2:0]      i_valid;
  logic [3*CW-1:0] i_cdb;
  logic [2:0]      i_ready;
  logic [CW-1:0]   cdb;
  logic            cdb_valid;
  logic            cdb_ready;
  logic [1:0]      last_grant;

  logic [4:0]      b_valid;
  logic [5*CWB-1:0] b_cdb_in;
  logic [4:0]      b_ready;
  logic [CWB-1:0]  b_cdb;
  logic            b_cdb_valid;
  logic            b_cdb_ready;
  logic [2:0]      b_last;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [CW-1:0] U0 = {4'h1, 32'h1000_0000};
  localparam logic [CW-1:0] U1 = {4'h2, 32'h2000_0001};
  localparam logic [CW-1:0] U2 = {4'h5, 32'h3000_0002};
  localparam logic [CW-1:0] WAA = {4'h3, 32'h0000_00AA};
  localparam logic [CWB-1:0] B0 = {4'h7, 8'h11};
  localparam logic [CWB-1:0] B3 = {4'h9, 8'h33};

  always #5 clk = ~clk;

  cdb_arbiter #(.N_UNITS(3), .RSV_ID_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_cdb(i_cdb), .i_ready(i_ready),
    .cdb(cdb), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .last_grant(last_grant)
  );

  cdb_arbiter #(.N_UNITS(5), .RSV_ID_W(4), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .flush(1'b0),
    .i_valid(b_valid), .i_cdb(b_cdb_in), .i_ready(b_ready),
    .cdb(b_cdb), .cdb_valid(b_cdb_valid), .cdb_ready(b_cdb_ready),
    .last_grant(b_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant-shape invariants checked every cycle on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("onehot0", 64'($onehot0(i_ready)), 64'd1);
      chk("ready_implies_valid", 64'(i_ready & ~i_valid), 64'd0);
      chk("b_onehot0", 64'($onehot0(b_ready)), 64'd1);
    end
  end

  // A held word must not change across an edge.
  always @(posedge clk) begin
    logic          hold;
    logic [CW-1:0] prev;
    hold = cdb_valid && !cdb_ready && !rst;
    prev = cdb;
    #1;
    if (hold) chk("hold_stable", 64'(cdb), 64'(prev));
  end

  initial begin
    rst = 1'b1; flush = 1'b0; cdb_ready = 1'b1;
    i_valid = 3'b111; i_cdb = {U2, U1, U0};
    b_valid = '0; b_cdb_in = '0; b_cdb_ready = 1'b1;

    // ---- reset ----
    #1;
    chk("rst_ready", 64'(i_ready), 64'd0);
    tick();
    tick();
    chk("rst_ready2", 64'(i_ready), 64'd0);
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb", 64'(cdb), 64'd0);
    chk("rst_last", 64'(last_grant), 64'd2);
    chk("rst_b_last", 64'(b_last), 64'd4);
    rst = 1'b0;

    // ---- round robin: 0,1,2,0,1,2 with no bubble ----
    for (int j = 0; j < 6; j++) begin
      #1;
      chk("rr_ready", 64'(i_ready), 64'(3'b001 << (j % 3)));
      tick();
      chk("rr_valid", 64'(cdb_valid), 64'd1);
      chk("rr_cdb", 64'(cdb), (j % 3 == 0) ? 64'(U0) : (j % 3 == 1) ? 64'(U1) : 64'(U2));
      chk("rr_last", 64'(last_grant), 64'(j % 3));
    end
    i_valid = 3'b000;
    tick();
    chk("drain_valid", 64'(cdb_valid), 64'd0);
    chk("drain_last", 64'(last_grant), 64'd2);

    // ---- single request from unit 1 ----
    i_valid = 3'b010; i_cdb = {U2, WAA, U0};
    #1;
    chk("single_ready", 64'(i_ready), 64'b010);
    tick();
    i_valid = 3'b000;
    chk("single_valid", 64'(cdb_valid), 64'd1);
    chk("single_tag", 64'(cdb[35:32]), 64'd3);
    chk("single_data", 64'(cdb[31:0]), 64'h0000_00AA);
    chk("single_last", 64'(last_grant), 64'd1);

    // ---- back-pressure ----
    i_valid = 3'b001; i_cdb = {U2, U1, U0};
    #1;
    chk("bp_load_ready", 64'(i_ready), 64'b001);
    tick();
    chk("bp_load_cdb", 64'(cdb), 64'(U0));
    cdb_ready = 1'b0; i_valid = 3'b110;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_ready", 64'(i_ready), 64'd0);
      tick();
      chk("bp_cdb", 64'(cdb), 64'(U0));
      chk("bp_valid", 64'(cdb_valid), 64'd1);
    end
    chk("bp_last", 64'(last_grant), 64'd0);
    cdb_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(i_ready), 64'b010);
    tick();
    i_valid = 3'b100;
    chk("bp_release_cdb", 64'(cdb), 64'(U1));
    chk("bp_release_last", 64'(last_grant), 64'd1);

    // ---- flush while held ----
    cdb_ready = 1'b0;
    #1;
    chk("fl_hold_ready", 64'(i_ready), 64'd0);
    tick();
    flush = 1'b1;
    #1;
    chk("fl_ready", 64'(i_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(cdb_valid), 64'd0);
    chk("fl_last", 64'(last_grant), 64'd1);
    #1;
    chk("fl_after_ready", 64'(i_ready), 64'b100);
    tick();
    chk("fl_after_cdb", 64'(cdb), 64'(U2));
    chk("fl_after_last", 64'(last_grant), 64'd2);
    chk("fl_after_valid", 64'(cdb_valid), 64'd1);

    // ---- reset mid-stream ----
    cdb_ready = 1'b1; i_valid = 3'b111;
    #1;
    chk("mr_ready0", 64'(i_ready), 64'b001);
    tick();
    chk("mr_cdb0", 64'(cdb), 64'(U0));
    rst = 1'b1;
    #1;
    chk("mr_rst_ready", 64'(i_ready), 64'd0);
    tick();
    rst = 1'b0;
    chk("mr_valid", 64'(cdb_valid), 64'd0);
    chk("mr_cdb", 64'(cdb), 64'd0);
    chk("mr_last", 64'(last_grant), 64'd2);
    #1;
    chk("mr_after_ready", 64'(i_ready), 64'b001);
    tick();
    chk("mr_after_cdb", 64'(cdb), 64'(U0));
    chk("mr_after_last", 64'(last_grant), 64'd0);
    i_valid = 3'b000;

    // ---- 5-unit wrap-around ----
    b_valid = 5'b01001;
    b_cdb_in = {{CWB{1'b0}}, B3, {CWB{1'b0}}, {CWB{1'b0}}, B0};
    #1;
    chk("b_last_pre", 64'(b_last), 64'd4);
    chk("b_ready0", 64'(b_ready), 64'b00001);
    tick();
    chk("b_cdb0", 64'(b_cdb), 64'(B0));
    chk("b_last0", 64'(b_last), 64'd0);
    b_valid = 5'b01000;
    #1;
    chk("b_ready3", 64'(b_ready), 64'b01000);
    tick();
    b_valid = 5'b00000;
    chk("b_cdb3", 64'(b_cdb), 64'(B3));
    chk("b_last3", 64'(b_last), 64'd3);
    chk("b_valid3", 64'(b_cdb_valid), 64'd1);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter and one-entry output register for the common data bus (CDB).
- Sits between the result producers (ALU, memory functional unit, MMU, and later units) and the CDB consumers (reservation stations, reorder buffer).
- Replaces fixed-priority CDB selection, so no unit can be starved.
- Registers the winning result, holds it under consumer back-pressure, and drops it on branch-misprediction flush.

Parameters:
- N_UNITS, 3, number of requesting functional units (≥2).
- RSV_ID_W, 4, reservation/ROB tag width.
- DATA_W, 32, result data width.
- CDB_W, RSV_ID_W+DATA_W, CDB word width; tag in [CDB_W-1:DATA_W], data in [DATA_W-1:0].

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  pred_miss from the branch unit; discards the held result.
- i_valid  in  N_UNITS  per-unit result-valid.
- i_cdb  in  N_UNITS×CDB_W  per-unit result word; unit k at [k*CDB_W +: CDB_W].
- i_ready  out  N_UNITS  per-unit grant; one-hot or zero.
- cdb  out  CDB_W  registered bus word.
- cdb_valid  out  1  bus word valid.
- cdb_ready  in  1  consumer accept; when low, the word is held.
- last_grant  out  $clog2(N_UNITS)  index of the most recently granted unit (debug/perf).

Behaviour:
- One clock domain, synchronous active-high reset.
- Reset values:
  - cdb=0, cdb_valid=0, i_ready=0.
  - last_grant=N_UNITS-1, so unit 0 has top priority first.
- Slot free: slot_free = ~cdb_valid | cdb_ready.
- Grant (combinational, cycle t):
  - If slot_free and ~flush and ~rst, scan units (last_grant+1) mod N_UNITS, +2, … with wrap-around.
  - The first k with i_valid[k]=1 gets i_ready[k]=1; all others get 0.
  - No valid requester → i_ready=0.
  - i_ready may depend on i_valid; i_valid must not depend on i_ready.
- Transfer: a handshake occurs when i_valid[k] & i_ready[k]. Then at the clk edge ending cycle t:
  - cdb ← i_cdb[k], cdb_valid ← 1, last_grant ← k.
- Latency: exactly 1 cycle from handshake to cdb_valid.
  - Full throughput: one result per cycle while cdb_ready=1 and requests are pending.
- Hold: cdb_valid=1 & cdb_ready=0 → cdb and cdb_valid stay stable; i_ready=0; last_grant unchanged.
- Drain: cdb_valid=1 & cdb_ready=1 with no new grant → cdb_valid ← 0. cdb holds its last value (don't-care).
- Simultaneous consume and grant: the new word replaces the old one in the same edge, with no bubble.
- last_grant changes only on a handshake, never on idle, hold or flush cycles.
- Flush:
  - In the flush cycle, i_ready=0.
  - Next edge: cdb_valid ← 0, whether or not cdb_ready is high. cdb value is don't-care.
  - last_grant is unchanged.
  - Units are responsible for squashing their own pending results.
- Reset mid-operation: any held word is lost, all outputs take their reset values next edge, and no handshake is reported in the reset cycle.
- Requester rule: a unit keeps i_valid and i_cdb stable until granted. The arbiter does not check this.
- Assertions (bench): $onehot0(i_ready); i_ready[k] implies i_valid[k]; cdb stable while cdb_valid & ~cdb_ready.

Test Plan:
- Single request: reset; unit 1 raises i_valid with i_cdb=tag 3/data 0x0000_00AA, cdb_ready=1 → i_ready=3'b010 same cycle; next cycle cdb_valid=1, cdb tag=3, data=0xAA; last_grant=1.
- Round robin: all three units hold valid continuously, cdb_ready=1 → grant order 0,1,2,0,1,2 on consecutive cycles; cdb_valid stays high for 6 cycles with no bubble.
- Back-pressure: word from unit 0 on the bus, cdb_ready=0 for 3 cycles with units 1 and 2 requesting → cdb unchanged, i_ready=0 for all 3 cycles; on the cycle cdb_ready=1, unit 1 is granted; next cycle unit 1's word is on cdb.
- Flush: word held with cdb_ready=0, assert flush 1 cycle with unit 2 valid → i_ready=0 that cycle; next cycle cdb_valid=0 and last_grant unchanged; the following cycle unit 2 is granted.
- Reset mid-operation: streaming with all units valid, assert rst 1 cycle → next cycle cdb_valid=0, cdb=0, last_grant=2; after rst drops, unit 0 is granted first.
- Parameter sweep: N_UNITS=5, last_grant=4, units 0 and 3 valid → unit 0 granted (wrap), then unit 3.
